// File: rtl/hs32_sram_pkg.sv
// Shared constants, FSM encoding and small helpers for the hs32 Wishbone-to-SRAM bridge.
package hs32_sram_pkg;

    localparam int SRAM_AW = 8;
    localparam int SRAM_DW = 32;

    localparam logic [SRAM_DW-1:0] MISS_DATA    = 32'h0000_0000;
    localparam logic [SRAM_DW-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RDATA  = 3'd3,
        ST_ACK    = 3'd4
    } state_e;

    // Reads never touch the macro's byte mask, so it is forced to zero.
    function automatic logic [3:0] write_mask(input logic we, input logic [3:0] sel);
        return we ? sel : 4'b0000;
    endfunction

endpackage

// File: rtl/hs32_wb_addr_decode.sv
// Combinational window hit and bank-select derivation for the SRAM bridge.
module hs32_wb_addr_decode #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          NBANKS    = 2
) (
    input  logic [31:0] adr_i,
    output logic        hit_o,
    output logic [1:0]  bank_o
);

    logic [1:0] bank_s;
    logic       unused_adr_s;

    // Bank bits start at adr[10]; the width follows the number of macros.
    generate
        if (NBANKS == 4) begin : g_bank4
            assign bank_s = adr_i[11:10];
        end else if (NBANKS == 2) begin : g_bank2
            assign bank_s = {1'b0, adr_i[10]};
        end else begin : g_bank1
            assign bank_s = 2'b00;
        end
    endgenerate

    assign hit_o  = (adr_i[31:12] == ADDR_BASE[31:12]) && ({30'd0, bank_s} < 32'(NBANKS));
    assign bank_o = bank_s;

    assign unused_adr_s = ^adr_i[11:0];

endmodule

// File: rtl/hs32_wb_sram_bridge.sv
// Wishbone-classic slave giving the management SoC access to port 0 of the hs32 buffer SRAMs.
// Optional: define HS32_BRIDGE_TIMEOUT_EN to force an error ack after ARB_TIMEOUT stalled cycles.
module hs32_wb_sram_bridge
    import hs32_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter int          NBANKS      = 2,
    parameter int          ARB_TIMEOUT = 64
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    input  logic                     port_busy_i,
    output logic                     port_req_o,
    output logic [NBANKS-1:0]        sram_csb_o,
    output logic                     sram_web_o,
    output logic [3:0]               sram_wmask_o,
    output logic [SRAM_AW-1:0]       sram_addr_o,
    output logic [SRAM_DW-1:0]       sram_din_o,
    input  logic [SRAM_DW*NBANKS-1:0] sram_dout_i
);

    state_e               state_q, state_d;
    logic                 hit_s;
    logic [1:0]           bank_s;
    logic                 bus_req_s;
    logic [SRAM_DW-1:0]   rd_word_s;

    logic [1:0]           bank_q, bank_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [SRAM_AW-1:0]   word_q, word_d;
    logic [SRAM_DW-1:0]   wdat_q, wdat_d;

    logic                 ack_q, ack_d;
    logic [SRAM_DW-1:0]   dat_q, dat_d;
    logic                 req_q, req_d;
    logic [NBANKS-1:0]    csb_q, csb_d;
    logic                 web_q, web_d;
    logic [3:0]           wmask_q, wmask_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [SRAM_DW-1:0]   din_q, din_d;

    assign bus_req_s = wbs_cyc_i & wbs_stb_i;

    hs32_wb_addr_decode #(
        .ADDR_BASE (ADDR_BASE),
        .NBANKS    (NBANKS)
    ) u_decode (
        .adr_i  (wbs_adr_i),
        .hit_o  (hit_s),
        .bank_o (bank_s)
    );

    // Select the read word of the latched bank.
    always_comb begin
        rd_word_s = '0;
        for (int b = 0; b < NBANKS; b++) begin
            rd_word_s = (bank_q == 2'(b)) ? sram_dout_i[b*SRAM_DW +: SRAM_DW] : rd_word_s;
        end
    end

`ifdef HS32_BRIDGE_TIMEOUT_EN
    logic [7:0] arb_cnt_q, arb_cnt_d;

    // Stall counter: zero outside ARB so it restarts on every ARB entry.
    always_comb begin
        if (state_q == ST_ARB) begin
            arb_cnt_d = arb_cnt_q + 8'd1;
        end else begin
            arb_cnt_d = 8'd0;
        end
    end

    // Stall counter register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            arb_cnt_q <= 8'd0;
        end else begin
            arb_cnt_q <= arb_cnt_d;
        end
    end
`else
    logic timeout_unused_s;
    assign timeout_unused_s = ^{8'(ARB_TIMEOUT), TIMEOUT_DATA};
`endif

    // Next-state logic; the bus is only sampled in IDLE, apart from cyc aborts.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        we_d    = we_q;
        sel_d   = sel_q;
        word_d  = word_q;
        wdat_d  = wdat_q;
        dat_d   = dat_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_req_s && hit_s) begin
                    state_d = ST_ARB;
                    bank_d  = bank_s;
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    word_d  = wbs_adr_i[9:2];
                    wdat_d  = wbs_dat_i;
                end else if (bus_req_s) begin
                    state_d = ST_ACK;
                    dat_d   = MISS_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (!port_busy_i) begin
                    state_d = ST_ACCESS;
`ifdef HS32_BRIDGE_TIMEOUT_EN
                end else if (arb_cnt_q == 8'(ARB_TIMEOUT)) begin
                    state_d = ST_ACK;
                    dat_d   = TIMEOUT_DATA;
`endif
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_ACCESS: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (we_q) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACK;
                    dat_d   = rd_word_s;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with it.
    always_comb begin
        ack_d   = (state_d == ST_ACK);
        req_d   = (state_d == ST_ARB);
        csb_d   = '1;
        web_d   = 1'b1;
        wmask_d = 4'b0000;
        addr_d  = addr_q;
        din_d   = din_q;
        if (state_d == ST_ACCESS) begin
            web_d   = ~we_q;
            wmask_d = write_mask(we_q, sel_q);
            addr_d  = word_q;
            din_d   = wdat_q;
            for (int b = 0; b < NBANKS; b++) begin
                csb_d[b] = (bank_q != 2'(b));
            end
        end else begin
            csb_d = '1;
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            bank_q  <= 2'b00;
            we_q    <= 1'b0;
            sel_q   <= 4'b0000;
            word_q  <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            req_q   <= 1'b0;
            csb_q   <= '1;
            web_q   <= 1'b1;
            wmask_q <= 4'b0000;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            req_q   <= req_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign port_req_o   = req_q;
    assign sram_csb_o   = csb_q;
    assign sram_web_o   = web_q;
    assign sram_wmask_o = wmask_q;
    assign sram_addr_o  = addr_q;
    assign sram_din_o   = din_q;

endmodule

// File: tb/tb_hs32_wb_sram_bridge.sv
// Self-checking bench for hs32_wb_sram_bridge: directed scenarios plus randomized traffic vs. a reference model.
module tb_hs32_wb_sram_bridge;

    localparam int NB = 2;

    logic            clk;
    logic            rst_n;
    logic            cyc, stb, we_i, busy;
    logic [3:0]      sel_i;
    logic [31:0]     adr_i, dat_i;
    logic            ack, req_o, web;
    logic [31:0]     dat_o, din;
    logic [NB-1:0]   csb;
    logic [3:0]      wmask;
    logic [7:0]      addr;
    logic [32*NB-1:0] sram_dout;

    int vectors;
    int miscompares;

    // Result slots filled by do_txn.
    int            lat, ccnt, ccyc, rq;
    logic [31:0]   rd, dv;
    logic [NB-1:0] cv;
    logic          wv;
    logic [3:0]    mv;
    logic [7:0]    av;

    // Reference model state.
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;

    hs32_wb_sram_bridge dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we_i),
        .wbs_sel_i    (sel_i),
        .wbs_adr_i    (adr_i),
        .wbs_dat_i    (dat_i),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dat_o),
        .port_busy_i  (busy),
        .port_req_o   (req_o),
        .sram_csb_o   (csb),
        .sram_web_o   (web),
        .sram_wmask_o (wmask),
        .sram_addr_o  (addr),
        .sram_din_o   (din),
        .sram_dout_i  (sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural sram_1rw1r port 0: registered read, byte-masked write.
    logic [31:0] mem  [NB][256];
    logic [31:0] dout_r [NB];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!csb[b]) begin
                if (!web) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wmask[i]) mem[b][addr][8*i +: 8] <= din[8*i +: 8];
                    end
                end else begin
                    dout_r[b] <= mem[b][addr];
                end
            end
        end
    end
    for (genvar g = 0; g < NB; g++) begin : g_dout
        assign sram_dout[32*g +: 32] = dout_r[g];
    end

    function automatic int bank_of(input logic [31:0] a);
        return int'((a >> 10) % NB);
    endfunction

    function automatic int key_of(input logic [31:0] a);
        return bank_of(a) * 256 + int'(a[9:2]);
    endfunction

    function automatic logic [NB-1:0] exp_csb(input logic [31:0] a);
        logic [NB-1:0] e;
        e = '1;
        e[bank_of(a)] = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Issue one bus cycle from a negedge; cycle 1 follows the first posedge. Busy covers cycles extra+1..extra+nbusy.
    task automatic do_txn(input logic we, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input int nbusy, input int extra);
        lat = -1; rd = '0; ccnt = 0; ccyc = -1; cv = '1; wv = 1'b1; mv = '0; av = '0; dv = '0; rq = 0;
        cyc = 1'b1; stb = 1'b1; we_i = we; sel_i = s; adr_i = a; dat_i = d; busy = 1'b0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (req_o === 1'b1) rq++;
            if (csb !== '1) begin
                ccnt++; ccyc = c; cv = csb; wv = web; mv = wmask; av = addr; dv = din;
            end
            if (ack === 1'b1) begin
                lat = c; rd = dat_o;
            end
            busy = (c >= 1 + extra) && (c <= nbusy + extra);
        end
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0; busy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if ({ack, req_o, web} !== 3'b001) begin miscompares++; $display("FAIL rst_ctrl: got ack/req/web=%b want 001", {ack, req_o, web}); end
        vectors++; if (csb !== '1) begin miscompares++; $display("FAIL rst_csb: got %b want all ones", csb); end
        vectors++; if ({dat_o, din, addr, wmask} !== 76'd0) begin miscompares++; $display("FAIL rst_data: got dat=%h din=%h addr=%h wmask=%h want 0", dat_o, din, addr, wmask); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        last_rd = 32'h0;
    endtask

    task automatic test_write_read();
        do_txn(1'b1, 32'h3000_0404, 4'hF, 32'hDEAD_BEEF, 0, 0);
        ref_mem[key_of(32'h3000_0404)] = 32'hDEAD_BEEF;
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL wr_lat: got %0d want 3", lat); end
        vectors++; if ({ccnt, ccyc} !== {32'd1, 32'd2}) begin miscompares++; $display("FAIL wr_csb_cycle: got cnt=%0d cyc=%0d want 1/2", ccnt, ccyc); end
        vectors++; if (cv !== exp_csb(32'h3000_0404)) begin miscompares++; $display("FAIL wr_csb: got %b want %b", cv, exp_csb(32'h3000_0404)); end
        vectors++; if ({wv, mv, av, dv} !== {1'b0, 4'hF, 8'h01, 32'hDEAD_BEEF}) begin miscompares++; $display("FAIL wr_port: got web=%b wmask=%h addr=%h din=%h want 0/f/01/deadbeef", wv, mv, av, dv); end
        vectors++; if (rq !== 1) begin miscompares++; $display("FAIL wr_req: got %0d req cycles want 1", rq); end
        @(negedge clk);
        do_txn(1'b0, 32'h3000_0404, 4'hF, 32'h0, 0, 0);
        last_rd = ref_mem[key_of(32'h3000_0404)];
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL rd_lat: got %0d want 4", lat); end
        vectors++; if (rd !== last_rd) begin miscompares++; $display("FAIL rd_data: got %h want %h", rd, last_rd); end
        vectors++; if ({wv, mv, ccyc} !== {1'b1, 4'h0, 32'd2}) begin miscompares++; $display("FAIL rd_port: got web=%b wmask=%h cyc=%0d want 1/0/2", wv, mv, ccyc); end
        @(negedge clk);
    endtask

    task automatic test_byte_mask();
        logic [31:0] e;
        do_txn(1'b1, 32'h3000_0804, 4'hF, 32'h1122_3344, 0, 0);
        ref_mem[key_of(32'h3000_0804)] = 32'h1122_3344;
        @(negedge clk);
        do_txn(1'b1, 32'h3000_0804, 4'b0101, 32'hAABB_CCDD, 0, 0);
        ref_mem[key_of(32'h3000_0804)] = merge(ref_mem[key_of(32'h3000_0804)], 32'hAABB_CCDD, 4'b0101);
        vectors++; if ({cv, mv} !== {exp_csb(32'h3000_0804), 4'b0101}) begin miscompares++; $display("FAIL mask_port: got csb=%b wmask=%b want %b/0101", cv, mv, exp_csb(32'h3000_0804)); end
        @(negedge clk);
        do_txn(1'b1, 32'h3000_0004, 4'b0000, 32'hFFFF_FFFF, 0, 0);
        vectors++; if ({lat, ccnt} !== {32'd3, 32'd1} || mv !== 4'b0000) begin miscompares++; $display("FAIL sel0_wr: got lat=%0d csb_cnt=%0d wmask=%b want 3/1/0000", lat, ccnt, mv); end
        @(negedge clk);
        do_txn(1'b0, 32'h3000_0004, 4'hF, 32'h0, 0, 0);
        e = ref_mem[key_of(32'h3000_0004)];
        last_rd = e;
        vectors++; if (rd !== e) begin miscompares++; $display("FAIL mask_rdback: got %h want %h", rd, e); end
        @(negedge clk);
    endtask

    task automatic test_busy();
        do_txn(1'b0, 32'h3000_0404, 4'hF, 32'h0, 5, 0);
        last_rd = ref_mem[key_of(32'h3000_0404)];
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL busy_lat: got %0d want 9", lat); end
        vectors++; if ({rq, ccnt, ccyc} !== {32'd6, 32'd1, 32'd7}) begin miscompares++; $display("FAIL busy_req_csb: got req=%0d csb_cnt=%0d csb_cyc=%0d want 6/1/7", rq, ccnt, ccyc); end
        vectors++; if (rd !== last_rd) begin miscompares++; $display("FAIL busy_data: got %h want %h", rd, last_rd); end
        @(negedge clk);
    endtask

    task automatic test_miss();
        do_txn(1'b0, 32'h2000_0000, 4'hF, 32'h0, 0, 0);
        last_rd = 32'h0;
        vectors++; if ({lat, ccnt, rq} !== {32'd1, 32'd0, 32'd0}) begin miscompares++; $display("FAIL miss_rd: got lat=%0d csb_cnt=%0d req=%0d want 1/0/0", lat, ccnt, rq); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL miss_data: got %h want 0", rd); end
        @(negedge clk);
        do_txn(1'b1, 32'h3000_1404, 4'hF, 32'h5555_AAAA, 0, 0);
        vectors++; if ({lat, ccnt} !== {32'd1, 32'd0}) begin miscompares++; $display("FAIL miss_wr: got lat=%0d csb_cnt=%0d want 1/0", lat, ccnt); end
        @(negedge clk);
        do_txn(1'b0, 32'h3000_0404, 4'hF, 32'h0, 0, 0);
        last_rd = ref_mem[key_of(32'h3000_0404)];
        vectors++; if (rd !== last_rd) begin miscompares++; $display("FAIL miss_dropped: got %h want %h", rd, last_rd); end
        @(negedge clk);
    endtask

    task automatic test_cyc_drop();
        int acks, csbs;
        acks = 0; csbs = 0;
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; sel_i = 4'hF; adr_i = 32'h3000_0008; busy = 1'b1;
        @(posedge clk); @(negedge clk);
        vectors++; if (req_o !== 1'b1) begin miscompares++; $display("FAIL drop_req_arb: got %b want 1", req_o); end
        @(posedge clk); @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); @(negedge clk);
        vectors++; if (req_o !== 1'b0) begin miscompares++; $display("FAIL drop_req_idle: got %b want 0", req_o); end
        for (int c = 0; c < 10; c++) begin
            if (ack === 1'b1) acks++;
            if (csb !== '1) csbs++;
            if (c == 4) busy = 1'b0;
            @(negedge clk);
        end
        vectors++; if ({acks, csbs} !== 64'd0) begin miscompares++; $display("FAIL drop_no_ack: got acks=%0d csb_cycles=%0d want 0/0", acks, csbs); end
        vectors++; if (dat_o !== last_rd) begin miscompares++; $display("FAIL drop_dat_hold: got %h want %h", dat_o, last_rd); end
        do_txn(1'b0, 32'h3000_0404, 4'hF, 32'h0, 0, 0);
        last_rd = ref_mem[key_of(32'h3000_0404)];
        vectors++; if ({lat, rd} !== {32'd4, last_rd}) begin miscompares++; $display("FAIL drop_recover: got lat=%0d dat=%h want 4/%h", lat, rd, last_rd); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_txn(1'b0, 32'h3000_0804, 4'hF, 32'h0, 0, 0);
        do_txn(1'b0, 32'h3000_0404, 4'hF, 32'h0, 0, 1);
        last_rd = ref_mem[key_of(32'h3000_0404)];
        vectors++; if ({lat, rd} !== {32'd5, last_rd}) begin miscompares++; $display("FAIL b2b_second: got lat=%0d dat=%h want 5/%h", lat, rd, last_rd); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic        we, miss, gap;
        logic [31:0] a, d, e_dat;
        logic [3:0]  s;
        int          nb, extra, e_lat;
        for (int b = 0; b < NB; b++) begin
            for (int w = 0; w < 4; w++) begin
                a = 32'h3000_0000 | (32'(b) << 10) | (32'(w) << 2);
                d = $urandom;
                do_txn(1'b1, a, 4'hF, d, 0, 0);
                ref_mem[key_of(a)] = d;
                vectors++; if (lat !== 3) begin miscompares++; $display("FAIL seed_lat: addr=%h got %0d want 3", a, lat); end
                @(negedge clk);
            end
        end
        for (int n = 0; n < 40; n++) begin
            we   = 1'($urandom_range(0, 1));
            miss = ($urandom_range(0, 7) == 0);
            gap  = 1'($urandom_range(0, 1));
            nb   = $urandom_range(0, 3);
            s    = 4'($urandom_range(0, 15));
            d    = $urandom;
            if (miss) begin
                a = ((n % 2) == 0 ? 32'h2000_0000 : 32'h3000_1000) | 32'($urandom_range(0, 4095));
            end else begin
                a = 32'h3000_0000 | (32'($urandom_range(0, NB - 1)) << 10) | (32'($urandom_range(0, 3)) << 2)
                    | (32'($urandom_range(0, 1)) << 11) | 32'($urandom_range(0, 3));
            end
            if (gap) @(negedge clk);
            extra = gap ? 0 : 1;
            do_txn(we, a, s, d, nb, extra);
            if (miss) begin
                e_lat = 1 + extra;
                last_rd = 32'h0;
            end else if (we) begin
                e_lat = 3 + nb + extra;
                ref_mem[key_of(a)] = merge(ref_mem[key_of(a)], d, s);
            end else begin
                e_lat = 4 + nb + extra;
                last_rd = ref_mem[key_of(a)];
            end
            e_dat = last_rd;
            vectors++; if (lat !== e_lat) begin miscompares++; $display("FAIL rnd_lat: n=%0d addr=%h we=%b got %0d want %0d", n, a, we, lat, e_lat); end
            vectors++; if (rd !== e_dat) begin miscompares++; $display("FAIL rnd_data: n=%0d addr=%h we=%b got %h want %h", n, a, we, rd, e_dat); end
            vectors++; if (ccnt !== (miss ? 0 : 1)) begin miscompares++; $display("FAIL rnd_csb: n=%0d addr=%h got %0d csb cycles want %0d", n, a, ccnt, miss ? 0 : 1); end
        end
        @(negedge clk);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        clk = 1'b0; rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0; busy = 1'b0;
        sel_i = 4'h0; adr_i = 32'h0; dat_i = 32'h0;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_busy();
        test_miss();
        test_cyc_drop();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
